alu_wb_stage: RTL

Result write-back stage directly downstream of the combinational ALU. Captures the ALU result and its ZCNV flags through a valid/ready handshake into a small show-ahead FIFO. Maintains the architectural status register under a set-flags control and flags unimplemented operation codes with a sticky error. Feeds the register-file write port and the branch/condition logic.

---
 rtl/alu_wb_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU write-back stage: show-ahead result FIFO, ZCNV status register, sticky op error.
// Optional sticky overflow accumulator enabled by defining ALU_WB_STICKY_OVF_EN.
module alu_wb_stage #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_r,
  input  logic [3:0]               in_flags,
  input  logic [2:0]               in_cntr,
  input  logic                     in_setf,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_r,
  output logic [3:0]               out_flags,
  output logic [3:0]               status,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_v
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [N+3:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [N+3:0]  head;
  logic          push;
  logic          legal;
  logic          push_legal;
  logic          pop;
  logic          arith_op;

  assign in_ready   = (count_q < CW'(DEPTH)) & ~flush;
  assign out_valid  = (count_q != '0);
  assign push       = in_valid & in_ready;
  assign legal      = ~(in_cntr[2] & in_cntr[1]);
  assign push_legal = push & legal;
  assign pop        = out_valid & out_ready & ~flush;
  assign arith_op   = (in_cntr[2:1] == 2'b00);
  assign count      = count_q;

  // Entries are never cleared; the empty case is masked on the output instead.
  always_ff @(posedge clk) begin
    if (push_legal) begin
      mem[wr_ptr] <= {in_r, in_flags};
    end
  end

  assign head      = mem[rd_ptr];
  assign out_r     = out_valid ? head[N+3:4] : '0;
  assign out_flags = out_valid ? head[3:0]   : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_legal) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_legal && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push_legal && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Logic/shift ops only define Z and N; C and V keep their last arithmetic value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= 4'b0000;
    end else if (push_legal && in_setf) begin
      if (arith_op) begin
        status <= in_flags;
      end else begin
        status <= {status[3], in_flags[2], status[1], in_flags[0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (flush) begin
      err <= 1'b0;
    end else if (push && !legal) begin
      err <= 1'b1;
    end
  end

`ifdef ALU_WB_STICKY_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_v <= 1'b0;
    end else if (flush) begin
      sticky_v <= 1'b0;
    end else if (push_legal && in_setf && arith_op) begin
      sticky_v <= sticky_v | in_flags[3];
    end
  end
`else
  assign sticky_v = 1'b0;
`endif

endmodule
